// File: rtl/seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg: definitions shared by the seq_gen pattern transmitter and the
// fsm_seq detector that listens to it.
//
// Contents
//   SEQ_LEN         bits per frame
//   PAT_A / PAT_B   frame patterns (PAT_A when the latched btn is 1, PAT_B when 0)
//   state_t         FSM state encoding: StIdle=00, StSend=01, StGap=10
//   select_pattern  maps a btn value to its frame pattern
// -----------------------------------------------------------------------------
package seq_pkg;

    localparam int unsigned SEQ_LEN = 6;

    localparam logic [SEQ_LEN-1:0] PAT_A = 6'b110010;
    localparam logic [SEQ_LEN-1:0] PAT_B = 6'b110110;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StSend = 2'b01,
        StGap  = 2'b10
    } state_t;

    function automatic logic [SEQ_LEN-1:0] select_pattern(input logic btn);
        return btn ? PAT_A : PAT_B;
    endfunction

endpackage

// File: rtl/seq_gen_piso.sv
// -----------------------------------------------------------------------------
// seq_piso: parallel-load, MSB-first shift register.
//
// A load takes priority over a shift. Each shift moves the register one place
// towards the MSB and fills the LSB with 0, so once every loaded bit has gone
// out, dout stays at 0.
//
// Parameters
//   WIDTH   register width (>= 2)
// Ports
//   clk     in   1       rising-edge clock
//   rst_n   in   1       asynchronous reset, active low; clears the register
//   load    in   1       load din on the next edge
//   shift   in   1       shift left one place on the next edge
//   din     in   WIDTH   parallel load data
//   dout    out  1       current MSB (a flop output)
// -----------------------------------------------------------------------------
module seq_piso #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= din;
        end else if (shift) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign dout = shreg[WIDTH-1];

endmodule

// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen: serial pattern transmitter.
//
// A start pulse seen in IDLE latches btn and sends one SEQ_LEN-bit frame on x,
// MSB first, one bit per clock (PAT_A when btn=1, PAT_B when btn=0). The first
// bit appears in the cycle after the start edge. A GAP of GAP_CYC idle cycles
// follows each frame. The module then returns to IDLE and pulses done for one
// cycle. start is ignored outside IDLE, and requests are not queued.
//
// Optional feature (build macro SEQ_GEN_LOOP_EN):
//   defined   - if loop=1 at the end of a frame (end of GAP, or end of SEND when
//               GAP_CYC=0), the pattern is reloaded from the current btn and the
//               next frame starts at once. There is no IDLE cycle and no done
//               pulse.
//   undefined - the loop input is ignored.
//
// Parameters
//   GAP_CYC    idle cycles after each frame (0 = no gap)
//   FCNT_W     width of frame_cnt
// Ports
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous reset, active low
//   start      in   1        request one frame; sampled only in IDLE
//   btn        in   1        pattern select; latched with start
//   loop       in   1        continuous mode (SEQ_GEN_LOOP_EN builds only)
//   x          out  1        serial data, registered
//   valid      out  1        high while x carries a frame bit
//   busy       out  1        high in SEND and GAP
//   done       out  1        one-cycle pulse on return to IDLE
//   frame_cnt  out  FCNT_W   completed frames, wraps silently
// -----------------------------------------------------------------------------
module seq_gen
    import seq_pkg::*;
#(
    parameter int unsigned GAP_CYC = 2,
    parameter int unsigned FCNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              btn,
    input  logic              loop,
    output logic              x,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int unsigned CNT_W = $clog2(SEQ_LEN);
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SEQ_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic last_bit;
    logic gap_end;
    logic frame_end;
    logic relaunch;
    logic load;
    logic shift;

    // -------------------------------------------------------------------------
    // Frame boundary decode and shift-register control
    // -------------------------------------------------------------------------
    always_comb begin
        last_bit  = (state == StSend) && (bit_cnt == LAST_BIT);
        gap_end   = (state == StGap) && (gap_cnt == GAP_LAST);
        // A frame ends where IDLE would be entered. That edge is the last gap
        // cycle, or the last bit when there is no gap.
        frame_end = (GAP_CYC == 0) ? last_bit : gap_end;
`ifdef SEQ_GEN_LOOP_EN
        relaunch  = frame_end && loop;
`else
        relaunch  = 1'b0;
`endif
        load      = ((state == StIdle) && start) || relaunch;
        shift     = (state == StSend);
    end

`ifndef SEQ_GEN_LOOP_EN
    logic unused_loop;
    assign unused_loop = loop ^ frame_end;
`endif

    // The shift register holds the latched pattern, so btn is effectively
    // frozen for the frame. Shifting in zeros keeps x at 0 once the frame
    // bits are gone.
    seq_piso #(
        .WIDTH (SEQ_LEN)
    ) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .din   (select_pattern(btn)),
        .dout  (x)
    );

    // -------------------------------------------------------------------------
    // Control FSM with registered valid/busy/done and the frame counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        state   <= StSend;
                        bit_cnt <= '0;
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end

                StSend: begin
                    if (last_bit) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        bit_cnt   <= '0;
                        if (GAP_CYC > 0) begin
                            state   <= StGap;
                            gap_cnt <= '0;
                            valid   <= 1'b0;
                        end else if (relaunch) begin
                            // Pattern reloaded this edge; stream continues.
                            state <= StSend;
                        end else begin
                            state <= StIdle;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                StGap: begin
                    if (gap_end) begin
                        gap_cnt <= '0;
                        if (relaunch) begin
                            state   <= StSend;
                            bit_cnt <= '0;
                            valid   <= 1'b1;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= StIdle;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
